// File: rtl/uart_autobaud_ctrl.sv
// Autobaud controller: times a 0x55 sync byte, loads the baud_gen divisor, gates uart_rx while busy.
// Define AUTOBAUD_CONSISTENCY_EN to also reject edge intervals that drift from the first one.
module uart_autobaud_ctrl #(
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned DVSR_RST = 54,
  parameter int unsigned DVSR_MIN = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rx_in_i,
  output logic [7:0] dvsr_o,
  output logic       rx_en_o,
  output logic       busy_o,
  output logic       locked_o,
  output logic       err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_MEASURE,
    S_CALC,
    S_SETTLE,
    S_DONE,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] m_q, m_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [2:0]       edges_q, edges_d;
  logic [7:0]       dvsr_q, dvsr_d;
  logic             rx_en_q, rx_en_d;
  logic             busy_q, busy_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             fall;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] bit_len;
  logic [CNT_W:0]   q_full;
  logic             q_ok;
  logic             ival_bad;

  assign fall    = rx_prev_q & ~rx_s_q;
  // Cycles since the start-bit edge, counting the current cycle.
  assign elapsed = cnt_q + CNT_W'(1);
  assign bit_len = m_q >> 3;
  // 8 bit times of 16 ticks each, rounded to nearest.
  assign q_full  = ({1'b0, m_q} + (CNT_W+1)'(64)) >> 7;
  assign q_ok    = (q_full >= (CNT_W+1)'(DVSR_MIN)) && (q_full <= (CNT_W+1)'(255));

`ifdef AUTOBAUD_CONSISTENCY_EN
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] i1_q, i1_d;
  logic [CNT_W-1:0] ival, idiff;

  always_comb begin
    ival     = elapsed - last_q;
    idiff    = (ival > i1_q) ? (ival - i1_q) : (i1_q - ival);
    ival_bad = (state_q == S_MEASURE) && fall && (edges_q >= 3'd2) && (idiff > (i1_q >> 3));
  end

  always_comb begin
    last_d = last_q;
    i1_d   = i1_q;
    if ((state_q == S_WAIT_START) && fall) begin
      last_d = '0;
    end else if ((state_q == S_MEASURE) && fall) begin
      last_d = elapsed;
      if (edges_q == 3'd1) i1_d = ival;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= '0;
      i1_q   <= '0;
    end else begin
      last_q <= last_d;
      i1_q   <= i1_d;
    end
  end
`else
  assign ival_bad = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    run_d    = run_q;
    edges_d  = edges_q;
    dvsr_d   = dvsr_q;
    rx_en_d  = rx_en_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_WAIT_START;
          busy_d   = 1'b1;
          rx_en_d  = 1'b0;
          locked_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_WAIT_START: begin
        if (fall) begin
          cnt_d   = '0;
          edges_d = 3'd1;
          state_d = S_MEASURE;
        end
      end
      S_MEASURE: begin
        cnt_d = elapsed;
        if (cnt_q == CNT_MAX) begin
          state_d = S_FAIL;
        end else if (fall) begin
          edges_d = edges_q + 3'd1;
          if (ival_bad) begin
            state_d = S_FAIL;
          end else if (edges_q == 3'd4) begin
            m_d     = elapsed;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (q_ok) begin
          dvsr_d  = q_full[7:0];
          cnt_d   = '0;
          run_d   = '0;
          state_d = S_SETTLE;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_SETTLE: begin
        // Wait for one full idle bit time so uart_rx never starts mid-frame.
        cnt_d = elapsed;
        run_d = rx_s_q ? (run_q + CNT_W'(1)) : '0;
        if (rx_s_q && (run_q == bit_len - CNT_W'(1))) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_FAIL;
        end
      end
      S_DONE: begin
        locked_d = 1'b1;
        rx_en_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      S_FAIL: begin
        err_d   = 1'b1;
        rx_en_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      run_q     <= '0;
      edges_q   <= '0;
      dvsr_q    <= 8'(DVSR_RST);
      rx_en_q   <= 1'b1;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_in_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      run_q     <= run_d;
      edges_q   <= edges_d;
      dvsr_q    <= dvsr_d;
      rx_en_q   <= rx_en_d;
      busy_q    <= busy_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign dvsr_o   = dvsr_q;
  assign rx_en_o  = rx_en_q;
  assign busy_o   = busy_q;
  assign locked_o = locked_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl; a second small-counter instance exercises the measurement timeout.
module tb_uart_autobaud_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, rx_in;
  logic [7:0] dvsr;
  logic       rx_en, busy, locked, err;
  logic       start2, rx2;
  logic [7:0] dvsr2;
  logic       rx_en2, busy2, locked2, err2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_autobaud_ctrl u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .rx_in_i  (rx_in),
    .dvsr_o   (dvsr),
    .rx_en_o  (rx_en),
    .busy_o   (busy),
    .locked_o (locked),
    .err_o    (err)
  );

  uart_autobaud_ctrl #(.CNT_W(10)) u_to (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start2),
    .rx_in_i  (rx2),
    .dvsr_o   (dvsr2),
    .rx_en_o  (rx_en2),
    .busy_o   (busy2),
    .locked_o (locked2),
    .err_o    (err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives npos bit positions of an 8N1 frame; positions 4,5 (data bits 3,4) last t34 cycles.
  task automatic send_frame(input logic [7:0] data, input int t, input int t34,
                            input int npos, input int poke);
    logic [9:0] bits;
    bits = {1'b1, data, 1'b0};
    for (int i = 0; i < npos; i++) begin
      int len;
      len   = (i == 4 || i == 5) ? t34 : t;
      rx_in = bits[i];
      if (i == poke) begin
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(len - 1);
      end else begin
        cyc(len);
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic begin_run(input string tag);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk({tag, " busy after start"}, 32'(busy), 1);
    chk({tag, " rx_en after start"}, 32'(rx_en), 0);
    chk({tag, " locked cleared"}, 32'(locked), 0);
    chk({tag, " err cleared"}, 32'(err), 0);
  endtask

  // rx_en must rise exactly (m>>3)+3 cycles after the stop bit reaches rx_in.
  task automatic lock_run(input string tag, input int t, input int t34, input int poke,
                          input int exp_dvsr);
    int m, l;
    m = 6 * t + 2 * t34;
    l = m >> 3;
    begin_run(tag);
    send_frame(8'h55, t, t34, 10, poke);
    cyc(l - t + 2);
    chk({tag, " rx_en still low"}, 32'(rx_en), 0);
    chk({tag, " busy still high"}, 32'(busy), 1);
    cyc(1);
    chk({tag, " rx_en"}, 32'(rx_en), 1);
    chk({tag, " locked"}, 32'(locked), 1);
    chk({tag, " err"}, 32'(err), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " dvsr"}, 32'(dvsr), exp_dvsr);
  endtask

  task automatic err_run(input string tag, input int t, input int t34, input int exp_dvsr);
    begin_run(tag);
    send_frame(8'h55, t, t34, 9, -1);
    cyc(2);
    chk({tag, " err"}, 32'(err), 1);
    chk({tag, " locked"}, 32'(locked), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " rx_en"}, 32'(rx_en), 1);
    chk({tag, " dvsr kept"}, 32'(dvsr), exp_dvsr);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    rx_in  = 1'b1;
    start2 = 1'b0;
    rx2    = 1'b1;
    cyc(3);
    rst = 1'b0;
    chk("rst dvsr", 32'(dvsr), 54);
    chk("rst rx_en", 32'(rx_en), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst locked", 32'(locked), 0);
    chk("rst err", 32'(err), 0);
    chk("rst to busy", 32'(busy2), 0);

    // Timeout: start bit then line stuck low; 10-bit counter saturates after 1023 counts.
    start2 = 1'b1;
    rx2    = 1'b0;
    cyc(1);
    start2 = 1'b0;
    chk("to busy", 32'(busy2), 1);
    chk("to rx_en low", 32'(rx_en2), 0);
    cyc(1026);
    chk("to err not yet", 32'(err2), 0);
    chk("to still busy", 32'(busy2), 1);
    cyc(1);
    chk("to err", 32'(err2), 1);
    chk("to busy done", 32'(busy2), 0);
    chk("to rx_en", 32'(rx_en2), 1);
    chk("to locked", 32'(locked2), 0);
    rx2 = 1'b1;

    // 868 clk/bit with a start pulse mid-measure: m=6944, q=54.
    lock_run("b115200", 868, 868, 3, 54);
    // 1736 clk/bit: m=13888, (13888+64)>>7 = 109.
    lock_run("b57600", 1736, 1736, -1, 109);
    // 4088 clk/bit: m=32704, q=256 just above range.
    err_run("q256", 4088, 4088, 109);
    // 24 clk/bit: m=192, q=2 is the smallest accepted divisor.
    lock_run("qmin", 24, 24, -1, 2);
    // 16 clk/bit: m=128, q=1 below range.
    err_run("q1", 16, 16, 2);

    // Reset in the middle of a measurement.
    begin_run("rstmid");
    rx_in = 1'b0;
    cyc(200);
    chk("rstmid busy", 32'(busy), 1);
    chk("rstmid dvsr held", 32'(dvsr), 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rstmid dvsr", 32'(dvsr), 54);
    chk("rstmid busy", 32'(busy), 0);
    chk("rstmid rx_en", 32'(rx_en), 1);
    chk("rstmid locked", 32'(locked), 0);
    rx_in = 1'b1;
    cyc(5);

    // Bits 3-4 stretched to 1085: third interval 2170 vs first 1736 (limit 217).
`ifdef AUTOBAUD_CONSISTENCY_EN
    err_run("stretch", 868, 1085, 54);
`else
    // m = 6*868 + 2*1085 = 7378, (7378+64)>>7 = 58.
    lock_run("stretch", 868, 1085, -1, 58);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
